// File: rtl/reflet_vga_compositor.sv
// reflet_vga_compositor: pipelined back-to-front alpha compositor for N layers.
// Layer 0 is the opaque bottom. Each layer k>0 is blended in its own registered
// stage. The layer-enable mask changes only at the v_sync active edge, and each
// pixel carries its mask down the pipe. Syncs and de are delayed by the same
// latency as the pixels.
// Optional chroma key: define REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN.

module reflet_vga_blend_stage #(
  parameter int D = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,       // layer enabled for this pixel
  input  logic           key_hit_i,  // top pixel matches chroma key
  input  logic [3*D-1:0] top_i,      // {R,G,B}
  input  logic [D-1:0]   a_i,
  input  logic [3*D-1:0] acc_i,
  output logic [3*D-1:0] acc_o
);
  logic [D:0]     ae;
  logic [3*D-1:0] acc_d, acc_q;

  // top*ae + acc*(2^D - ae), scaled back by 2^D; ae spans 0..2^D inclusive
  function automatic logic [D-1:0] mix(input logic [D-1:0] top,
                                       input logic [D-1:0] acc,
                                       input logic [D:0]   e);
    logic [D:0]   inv;
    logic [2*D:0] sum;
    inv = {1'b1, {D{1'b0}}} - e;
    sum = {{(D+1){1'b0}}, top} * {{D{1'b0}}, e}
        + {{(D+1){1'b0}}, acc} * {{D{1'b0}}, inv};
    return D'(sum >> D);
  endfunction

  // expand alpha so that max alpha is exact; keyed pixels become transparent
  always_comb begin
    ae    = key_hit_i ? '0 : ({1'b0, a_i} + {{D{1'b0}}, a_i[D-1]});
    acc_d = acc_i;
    if (en_i)
      for (int c = 0; c < 3; c++)
        acc_d[c*D +: D] = mix(top_i[c*D +: D], acc_i[c*D +: D], ae);
  end

  // one cycle per stage whether or not the layer is enabled
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;

  assign acc_o = acc_q;
endmodule

module reflet_vga_compositor #(
  parameter int layers          = 3,
  parameter int color_depth     = 8,
  parameter bit sync_active_low = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          h_sync_in,
  input  logic                          v_sync_in,
  input  logic                          de_in,
  input  logic [layers*color_depth-1:0] R_in,
  input  logic [layers*color_depth-1:0] G_in,
  input  logic [layers*color_depth-1:0] B_in,
  input  logic [layers*color_depth-1:0] a_in,
  input  logic                          cfg_write,
  input  logic [layers-1:0]             cfg_mask,
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
  input  logic                          key_write,
  input  logic [3*color_depth-1:0]      key_color,
`endif
  output logic                          h_sync,
  output logic                          v_sync,
  output logic [color_depth-1:0]        R_out,
  output logic [color_depth-1:0]        G_out,
  output logic [color_depth-1:0]        B_out
);
  localparam int   L         = layers;
  localparam int   D         = color_depth;
  localparam logic SYNC_IDLE = sync_active_low;

  typedef struct packed {
    logic         de;
    logic         hs;
    logic         vs;
    logic [L-1:0] mask;
  } side_t;

  side_t [L-1:0]  side_q;          // de/sync/mask delay line, one entry per stage
  logic [3*D-1:0] acc [L];         // acc[k]: registered result of stage k
  logic [3*D-1:0] base_q;
  logic           vs_prev_q;
  logic [L-1:0]   pend_q, pend_d, act_q, act_d, in_mask;
  logic           vs_edge;

  // frame-start detect; the pixel on the edge cycle already uses the new mask
  always_comb begin
    vs_edge = (v_sync_in != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
    in_mask = vs_edge ? pend_q : act_q;
    act_d   = in_mask;
    pend_d  = cfg_write ? (cfg_mask | L'(1)) : pend_q;
  end

  // mask double buffer and sync edge history
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vs_prev_q <= SYNC_IDLE;
      pend_q    <= '1;
      act_q     <= '1;
    end else begin
      vs_prev_q <= v_sync_in;
      pend_q    <= pend_d;
      act_q     <= act_d;
    end

  // stage 0: bottom layer plus the side-band delay line
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base_q <= '0;
      for (int i = 0; i < L; i++) side_q[i] <= '{1'b0, SYNC_IDLE, SYNC_IDLE, {L{1'b1}}};
    end else begin
      base_q    <= {R_in[0 +: D], G_in[0 +: D], B_in[0 +: D]};
      side_q[0] <= '{de_in, h_sync_in, v_sync_in, in_mask};
      for (int i = 1; i < L; i++) side_q[i] <= side_q[i-1];
    end

  assign acc[0] = base_q;

`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
  logic [3*D-1:0] key_q;

  // key takes effect immediately, not at frame start
  always_ff @(posedge clk or negedge reset)
    if (!reset)         key_q <= '0;
    else if (key_write) key_q <= key_color;
`endif

  for (genvar k = 1; k < L; k++) begin : g_layer
    logic [4*D-1:0] skew_q [k];   // {R,G,B,A}, k deep so layer k meets its stage
    logic           key_hit;

    // skew layer k by k cycles
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        for (int i = 0; i < k; i++) skew_q[i] <= '0;
      end else begin
        skew_q[0] <= {R_in[k*D +: D], G_in[k*D +: D], B_in[k*D +: D], a_in[k*D +: D]};
        for (int i = 1; i < k; i++) skew_q[i] <= skew_q[i-1];
      end

`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    assign key_hit = (skew_q[k-1][4*D-1:D] == key_q);
`else
    assign key_hit = 1'b0;
`endif

    reflet_vga_blend_stage #(.D(D)) u_blend (
      .clk       (clk),
      .reset     (reset),
      .en_i      (side_q[k-1].mask[k]),
      .key_hit_i (key_hit),
      .top_i     (skew_q[k-1][4*D-1:D]),
      .a_i       (skew_q[k-1][D-1:0]),
      .acc_i     (acc[k-1]),
      .acc_o     (acc[k])
    );
  end

  // outputs come straight from the last stage; blank outside the visible area
  always_comb begin
    h_sync                = side_q[L-1].hs;
    v_sync                = side_q[L-1].vs;
    {R_out, G_out, B_out} = side_q[L-1].de ? acc[L-1] : '0;
  end

  // layer 0 alpha, mask bit 0 and the spent mask at the output carry no meaning
  logic unused_sink;
  assign unused_sink = ^{a_in[D-1:0], cfg_mask[0], side_q[L-1].mask};
endmodule

// File: tb/tb_reflet_vga_compositor.sv
// Directed bench for reflet_vga_compositor: a queue-based reference model is
// compared every cycle, and literal expectations pin key points of the model.
module tb_reflet_vga_compositor;
  localparam int L = 3;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset, h_sync_in, v_sync_in, de_in, cfg_write;
  logic [L*D-1:0] R_in, G_in, B_in, a_in;
  logic [L-1:0]   cfg_mask;
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
  logic           key_write;
  logic [3*D-1:0] key_color;
`endif
  logic           h_sync, v_sync;
  logic [D-1:0]   R_out, G_out, B_out;
  int             total = 0;
  int             bad = 0;

  reflet_vga_compositor #(.layers(L), .color_depth(D), .sync_active_low(1'b1)) dut (
    .clk(clk), .reset(reset), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .de_in(de_in), .R_in(R_in), .G_in(G_in), .B_in(B_in), .a_in(a_in),
    .cfg_write(cfg_write), .cfg_mask(cfg_mask),
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    .key_write(key_write), .key_color(key_color),
`endif
    .h_sync(h_sync), .v_sync(v_sync), .R_out(R_out), .G_out(G_out), .B_out(B_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic [D-1:0] r;
    logic [D-1:0] g;
    logic [D-1:0] b;
  } pix_t;

  localparam pix_t IDLE = '{1'b1, 1'b1, 8'd0, 8'd0, 8'd0};

  pix_t           q[$];
  pix_t           exp_cur = IDLE;
  logic [L-1:0]   m_pend, m_act, m_use;
  logic           m_prev_vs;
  logic [3*D-1:0] m_key;

  // composite the pixel currently on the inputs with mask m
  function automatic pix_t model_pixel(input logic [L-1:0] m);
    int   acc[3];
    int   top[3];
    int   ae;
    pix_t p;
    acc[0] = R_in[D-1:0]; acc[1] = G_in[D-1:0]; acc[2] = B_in[D-1:0];
    for (int k = 1; k < L; k++) begin
      top[0] = R_in[k*D +: D]; top[1] = G_in[k*D +: D]; top[2] = B_in[k*D +: D];
      ae = a_in[k*D +: D];
      if (ae >= (1 << (D-1))) ae = ae + 1;
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
      if ({R_in[k*D +: D], G_in[k*D +: D], B_in[k*D +: D]} == m_key) ae = 0;
`endif
      if (m[k])
        for (int c = 0; c < 3; c++)
          acc[c] = (top[c] * ae + acc[c] * ((1 << D) - ae)) / (1 << D);
    end
    p.hs = h_sync_in;
    p.vs = v_sync_in;
    p.r  = de_in ? D'(acc[0]) : '0;
    p.g  = de_in ? D'(acc[1]) : '0;
    p.b  = de_in ? D'(acc[2]) : '0;
    return p;
  endfunction

  // reference: mask bookkeeping at the input, then an L-cycle delay queue
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = '1; m_act = '1; m_prev_vs = 1'b1; m_key = '0;
      q.delete();
      for (int i = 0; i < L-1; i++) q.push_back(IDLE);
      exp_cur = IDLE;
    end else begin
      m_use = (m_prev_vs && !v_sync_in) ? m_pend : m_act;
      m_act = m_use;
      if (cfg_write) m_pend = cfg_mask | 3'b001;
      m_prev_vs = v_sync_in;
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
      if (key_write) m_key = key_color;
`endif
      q.push_back(model_pixel(m_use));
      exp_cur = q.pop_front();
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    pix_t dut_px;
    dut_px = '{h_sync, v_sync, R_out, G_out, B_out};
    total++;
    if (dut_px !== exp_cur) begin
      bad++;
      $display("FAIL model t=%0t got hs=%b vs=%b rgb=%h_%h_%h want hs=%b vs=%b rgb=%h_%h_%h",
               $time, dut_px.hs, dut_px.vs, dut_px.r, dut_px.g, dut_px.b,
               exp_cur.hs, exp_cur.vs, exp_cur.r, exp_cur.g, exp_cur.b);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic layer(input int k, input int r, input int g, input int b, input int a);
    R_in[k*D +: D] = D'(r);
    G_in[k*D +: D] = D'(g);
    B_in[k*D +: D] = D'(b);
    a_in[k*D +: D] = D'(a);
  endtask

  initial begin
    reset = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; de_in = 1'b0;
    cfg_write = 1'b0; cfg_mask = '0;
    R_in = '0; G_in = '0; B_in = '0; a_in = '0;
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    key_write = 1'b0; key_color = '0;
`endif
    layer(0, 100, 10, 20, 0);
    layer(1, 200, 30, 40, 255);
    layer(2, 50, 60, 70, 0);
    step(3);
    chk("rst_r", R_out, 0);
    chk("rst_hs", h_sync, 1);
    chk("rst_vs", v_sync, 1);

    // release together with the first visible pixel
    reset = 1'b1; de_in = 1'b1;
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    key_write = 1'b1; key_color = 24'h00FF00;
`endif
    step(1);
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    key_write = 1'b0;
`endif
    step(1); chk("lat_blank", R_out, 0);
    step(1); chk("lat_first", R_out, 200);

    layer(1, 200, 30, 40, 128); step(L); chk("alpha128", R_out, 150);
    layer(2, 50, 60, 70, 255);  step(L); chk("l2_top", R_out, 50);

    // mask written mid-frame holds until the v_sync active edge
    cfg_mask = 3'b011; cfg_write = 1'b1; step(1); cfg_write = 1'b0;
    step(4); chk("mask_pend", R_out, 50);
    v_sync_in = 1'b0;
    step(L-1); chk("mask_pre", R_out, 50); chk("vs_pre", v_sync, 1);
    step(1);   chk("mask_new", R_out, 150); chk("vs_out", v_sync, 0);
    step(1); v_sync_in = 1'b1;

    // write coinciding with the edge: old pending becomes active
    layer(2, 50, 60, 70, 0); step(L); chk("l2_clear", R_out, 150);
    cfg_mask = 3'b101; cfg_write = 1'b1; step(1); cfg_write = 1'b0;
    step(3); chk("pend_101", R_out, 150);
    cfg_mask = 3'b111; cfg_write = 1'b1; v_sync_in = 1'b0;
    step(1); cfg_write = 1'b0;
    step(L-1); chk("simul_old", R_out, 100);
    step(2); v_sync_in = 1'b1;
    step(5); chk("frame_hold", R_out, 100);
    // last write in a frame wins
    cfg_mask = 3'b001; cfg_write = 1'b1; step(1);
    cfg_mask = 3'b111; step(1); cfg_write = 1'b0;
    step(2); v_sync_in = 1'b0;
    step(L); chk("next_frame", R_out, 150);
    step(2); v_sync_in = 1'b1;

    // blanking and h_sync pulse alignment/width
    layer(0, 255, 255, 255, 0); layer(1, 255, 255, 255, 255); layer(2, 255, 255, 255, 255);
    de_in = 1'b0; h_sync_in = 1'b0;
    step(2); chk("hs_pre", h_sync, 1); h_sync_in = 1'b1;
    step(1); chk("hs_out", h_sync, 0);
    chk("blank_r", R_out, 0); chk("blank_g", G_out, 0); chk("blank_b", B_out, 0);
    step(1); chk("hs_width", h_sync, 0);
    step(1); chk("hs_end", h_sync, 1);

    // chroma key on layer 1
    de_in = 1'b1;
    layer(0, 100, 10, 20, 0); layer(1, 0, 255, 0, 255); layer(2, 50, 60, 70, 0);
    step(L);
`ifdef REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN
    chk("chroma", R_out, 100);
`else
    chk("chroma", R_out, 0);
`endif

    // asynchronous reset mid-frame
    layer(1, 200, 30, 40, 255); step(L); chk("pre_rst", R_out, 200);
    #1 reset = 1'b0;
    #1 chk("arst_r", R_out, 0); chk("arst_hs", h_sync, 1);
    step(1); reset = 1'b1;
    step(2); chk("post_rst_blank", R_out, 0);
    step(1); chk("post_rst", R_out, 200);
    step(L);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reflet_vga_compositor.md
Name: reflet_VGA_compositor

Overview:
- Pipelined N-layer alpha compositor placed between the per-layer pixel sources (bitmap, text, sprite layers) and the VGA pins.
- Blends layers back-to-front, one registered stage per layer, so throughput is one pixel per clock.
- Delays h_sync, v_sync and display-enable by the same latency, so sync alignment does not need hand-counting.
- A runtime layer-enable mask is double-buffered and takes effect only at frame start.

Parameters:
- layers, 3: number of layers, minimum 2; layer 0 is the bottom layer and is always opaque.
- color_depth, 8: bits per colour and alpha channel.
- sync_active_low, 1: 1 = sync pulses are active-low, 0 = active-high. Applies to both inputs and outputs.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- h_sync_in  input  1  horizontal sync from the timing generator
- v_sync_in  input  1  vertical sync from the timing generator
- de_in  input  1  display enable, 1 = visible pixel
- R_in  input  layers*color_depth  red channel; layer k occupies bits [k*color_depth +: color_depth]
- G_in  input  layers*color_depth  green channel, same packing
- B_in  input  layers*color_depth  blue channel, same packing
- a_in  input  layers*color_depth  alpha channel, same packing; the layer 0 slice is ignored
- cfg_write  input  1  load cfg_mask into the pending mask register
- cfg_mask  input  layers  layer enable mask; bit 0 is ignored (layer 0 is always on)
- h_sync  output  1  delayed horizontal sync
- v_sync  output  1  delayed vertical sync
- R_out  output  color_depth  composited red
- G_out  output  color_depth  composited green
- B_out  output  color_depth  composited blue

Behaviour:
- Reset (reset=0, asynchronous):
  - R_out, G_out and B_out are 0.
  - h_sync and v_sync sit at the inactive level (1 if sync_active_low, else 0).
  - All pipeline, skew and delay registers are cleared; the delayed de and sync contents are cleared to de=0 and inactive sync.
  - Pending mask and active mask are all ones.
- Latency: L = layers cycles from inputs to outputs.
  - Stage 0 registers layer 0 RGB.
  - Stage k (1..layers-1) blends layer k onto the stage k-1 result.
  - Layer k inputs pass through k skew registers so every layer samples the same pixel.
  - h_sync, v_sync and de pass through an L-deep shift register.
- Blend arithmetic, per channel:
  - ae = a + a[color_depth-1], color_depth+1 bits wide, so alpha 0 maps to 0 and full alpha maps to 2^color_depth.
  - out = (top*ae + acc*(2^color_depth - ae)) >> color_depth, computed at 2*color_depth+1 bits and then truncated.
  - a = 0 gives acc exactly; a = max gives top exactly; no saturation is needed.
- A disabled layer k (active mask bit k = 0) passes acc through its stage unchanged. The stage keeps its 1-cycle latency.
- Blanking: if the delayed de is 0 at the output, R_out, G_out and B_out are forced to 0.
- Mask handling:
  - cfg_write=1 loads pending_mask <= cfg_mask | 1 on that clock edge.
  - active_mask <= pending_mask on the cycle where v_sync_in transitions from inactive to active (edge detector registered on the input side).
  - The mask is sampled at the input side of the pipeline. Each pixel carries the mask value it entered with, so a frame is never split across masks.
- Simultaneous cfg_write and v_sync edge: the old pending value goes to active; the new value stays pending until the next frame.
- Multiple cfg_write pulses within one frame: the last write wins.
- Reset mid-frame: the output returns to the reset state immediately. After release, the first L cycles output blanked pixels with inactive sync.

Optional Feature:
- Macro: REFLET_VGA_COMPOSITOR_CHROMA_KEY_EN.
- When defined:
  - Adds input ports key_write (1 bit) and key_color (3*color_depth bits, packed {R,G,B}), plus a key register that resets to 0.
  - key_write loads the key register immediately; it is not frame-synchronised.
  - For layers 1..layers-1, a pixel whose RGB equals the key is treated as a = 0. The compare is done in the same stage as the blend, so latency is unchanged.
- When undefined: no extra ports or registers; alpha is used as supplied.

Test Plan:
- Reset held, then released with de_in=0 -> outputs 0 and syncs at 1 (active-low) for L=3 cycles; the first valid pixel appears exactly 3 cycles after it is applied.
- layers=3, depth 8: layer0 R=100; layer1 R=200 a=255; layer2 a=0 -> R_out=200. Change layer1 a to 128 -> R_out=150 ((200*129 + 100*127) >> 8).
- layer2 R=50 a=255 with mask 3'b011 written mid-frame -> R_out keeps showing the layer2 blend (50) until the v_sync active edge. Pixels entering from that edge onward show 150, arriving 3 cycles later.
- cfg_write on the same cycle as the v_sync falling edge (active-low) -> the previous pending mask is applied; the new mask is applied only at the following frame.
- de_in=0 with all layers R=255 a=255 -> R_out=G_out=B_out=0. h_sync and v_sync pulses emerge exactly L cycles after input with their widths preserved.
- Chroma key: with the macro defined, key=0x00FF00 and layer1 pixel {0,255,0} a=255 over layer0 R=100 -> R_out=100. With the macro undefined, the same stimulus gives R_out=0.
